// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer and its surroundings
// (vga_timing pacing, paddle sources, draw stages).
// Timing contract: inputs are sampled on every rising clk edge. Outputs are registered.
// Outputs change only on the edge that follows a vblnk_in rise, or on a start/reset edge.
interface pong_game_ctrl_if;
  logic        vblnk_in;
  logic        start;
  logic [10:0] paddle_l_y;
  logic [10:0] paddle_r_y;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic [2:0]  state;
  logic        game_over;

  modport master (
    output vblnk_in, start, paddle_l_y, paddle_r_y,
    input  ball_x, ball_y, score_l, score_r, state, game_over
  );

  modport slave (
    input  vblnk_in, start, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, score_l, score_r, state, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: owns ball position/direction, scores and the game FSM,
// and advances one step per video frame (rising edge of vblnk_in).
module pong_game_ctrl #(
  parameter int HOR_PIXELS   = 800,
  parameter int VER_PIXELS   = 600,
  parameter int BALL_SIZE    = 16,
  parameter int PADDLE_W     = 16,
  parameter int PADDLE_H     = 96,
  parameter int PADDLE_X_L   = 32,
  parameter int PADDLE_X_R   = 752,
  parameter int BALL_SPEED   = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input logic             clk,
  input logic             rst,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam int          CNT_W  = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] X_CTR  = 11'((HOR_PIXELS - BALL_SIZE) / 2);
  localparam logic [10:0] Y_CTR  = 11'((VER_PIXELS - BALL_SIZE) / 2);
  localparam logic [11:0] X_MAX  = 12'(HOR_PIXELS - BALL_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(VER_PIXELS - BALL_SIZE);
  localparam logic [11:0] SPEED  = 12'(BALL_SPEED);
  localparam logic [11:0] SIZE   = 12'(BALL_SIZE);
  localparam logic [11:0] PAD_H  = 12'(PADDLE_H);
  localparam logic [11:0] FACE_L = 12'(PADDLE_X_L + PADDLE_W);
  localparam logic [11:0] FACE_R = 12'(PADDLE_X_R);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_t           state_q, state_n;
  logic [10:0]      x_q, x_n, y_q, y_n;
  logic             dx_q, dx_n;  // 1 = moving right
  logic             dy_q, dy_n;  // 1 = moving down
  logic [3:0]       sl_q, sl_n, sr_q, sr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             go_q, go_n;
  logic             vblnk_d;
  logic             tick;

  assign tick = bus.vblnk_in & ~vblnk_d;

  // Geometry is evaluated in 12 bits so sums near the screen edge never wrap.
  logic [11:0] bx, by, pl, pr;
  logic        ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

  assign bx = {1'b0, x_q};
  assign by = {1'b0, y_q};
  assign pl = {1'b0, bus.paddle_l_y};
  assign pr = {1'b0, bus.paddle_r_y};

  assign ovl_l  = (by + SIZE > pl) && (by < pl + PAD_H);
  assign ovl_r  = (by + SIZE > pr) && (by < pr + PAD_H);
  assign hit_l  = ~dx_q && (bx >= FACE_L) && (bx <= FACE_L + SPEED) && ovl_l;
  assign hit_r  = dx_q && (bx + SIZE <= FACE_R) && (bx + SIZE + SPEED >= FACE_R) && ovl_r;
  assign miss_l = ~dx_q && ~hit_l && (bx < SPEED);
  assign miss_r = dx_q && ~hit_r && (bx + SPEED > X_MAX);

  logic [10:0] y_play;
  logic        dy_play;

  always_comb begin
    y_play  = y_q;
    dy_play = dy_q;
    if (!dy_q && (by <= SPEED)) begin
      y_play  = '0;
      dy_play = 1'b1;
    end else if (dy_q && (by + SPEED >= Y_MAX)) begin
      y_play  = Y_MAX[10:0];
      dy_play = 1'b0;
    end else if (dy_q) begin
      y_play  = 11'(by + SPEED);
    end else begin
      y_play  = 11'(by - SPEED);
    end
  end

  function automatic logic [3:0] bump(input logic [3:0] s);
    return (s >= WIN) ? s : s + 4'd1;
  endfunction

  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    y_n     = y_q;
    dx_n    = dx_q;
    dy_n    = dy_q;
    sl_n    = sl_q;
    sr_n    = sr_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_SERVE;
          cnt_n   = '0;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_n = S_PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (tick) begin
          y_n  = y_play;
          dy_n = dy_play;
          if (hit_l) begin
            x_n  = FACE_L[10:0];
            dx_n = 1'b1;
          end else if (hit_r) begin
            x_n  = 11'(FACE_R - SIZE);
            dx_n = 1'b0;
          end else if (miss_l) begin
            x_n     = '0;
            sr_n    = bump(sr_q);
            dx_n    = 1'b0;
            state_n = S_POINT;
          end else if (miss_r) begin
            x_n     = X_MAX[10:0];
            sl_n    = bump(sl_q);
            dx_n    = 1'b1;
            state_n = S_POINT;
          end else if (dx_q) begin
            x_n = 11'(bx + SPEED);
          end else begin
            x_n = 11'(bx - SPEED);
          end
        end
      end
      S_POINT: begin
        // Ball stays at the edge for one frame; serve direction was set on the miss.
        if (tick) begin
          if ((sl_q == WIN) || (sr_q == WIN)) begin
            state_n = S_GAME_OVER;
          end else begin
            x_n     = X_CTR;
            y_n     = Y_CTR;
            cnt_n   = '0;
            state_n = S_SERVE;
          end
        end
      end
      S_GAME_OVER: begin
        if (bus.start) begin
          sl_n    = '0;
          sr_n    = '0;
          x_n     = X_CTR;
          y_n     = Y_CTR;
          dx_n    = 1'b1;
          dy_n    = 1'b1;
          cnt_n   = '0;
          state_n = S_SERVE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    go_n = (state_n == S_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      sl_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      vblnk_d <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      dx_q    <= dx_n;
      dy_q    <= dy_n;
      sl_q    <= sl_n;
      sr_q    <= sr_n;
      cnt_q   <= cnt_n;
      go_q    <= go_n;
      vblnk_d <= bus.vblnk_in;
    end
  end

  assign bus.ball_x    = x_q;
  assign bus.ball_y    = y_q;
  assign bus.score_l   = sl_q;
  assign bus.score_r   = sr_q;
  assign bus.state     = state_q;
  assign bus.game_over = go_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a frame-level game model checked every cycle,
// plus hand-computed literal checkpoints along one scripted match.
module tb_pong_game_ctrl;
  localparam int X_C = 392;
  localparam int Y_C = 292;
  localparam int X_MAX = 784;
  localparam int Y_MAX = 584;
  localparam int SPD = 4;
  localparam int FACE_L = 48;
  localparam int FACE_R = 752;
  localparam int PH = 96;
  localparam int BS = 16;
  localparam int WIN = 9;
  localparam int SERVE = 60;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

  logic clk;
  logic rst;
  pong_game_ctrl_if gif();

  pong_game_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  bit cmp_en = 0;
  bit l_away = 0;
  bit r_away = 0;

  // Game model state (ints, frame-level rules).
  int m_state, m_x, m_y, m_sl, m_sr, m_serve_frames;
  bit m_right, m_down, m_vprev;

  task automatic model_reset();
    m_state = M_IDLE; m_x = X_C; m_y = Y_C; m_sl = 0; m_sr = 0;
    m_serve_frames = 0; m_right = 1; m_down = 1; m_vprev = 0;
  endtask

  function automatic bit overlaps(int by, int py);
    return (by + BS > py) && (by < py + PH);
  endfunction

  task automatic model_play_frame();
    int ny, nx;
    bit nd, nr;
    int pl, pr;
    pl = int'(gif.paddle_l_y);
    pr = int'(gif.paddle_r_y);
    nd = m_down;
    nr = m_right;
    if (!m_down && m_y <= SPD) begin ny = 0; nd = 1; end
    else if (m_down && m_y + SPD >= Y_MAX) begin ny = Y_MAX; nd = 0; end
    else ny = m_down ? m_y + SPD : m_y - SPD;
    if (!m_right && m_x >= FACE_L && m_x - SPD <= FACE_L && overlaps(m_y, pl)) begin
      nx = FACE_L; nr = 1;
    end else if (m_right && m_x + BS <= FACE_R && m_x + BS + SPD >= FACE_R && overlaps(m_y, pr)) begin
      nx = FACE_R - BS; nr = 0;
    end else if (!m_right && m_x < SPD) begin
      nx = 0; m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr; m_state = M_POINT;
    end else if (m_right && m_x + SPD > X_MAX) begin
      nx = X_MAX; m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl; m_state = M_POINT;
    end else begin
      nx = m_right ? m_x + SPD : m_x - SPD;
    end
    m_x = nx; m_y = ny; m_down = nd; m_right = nr;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      bit tick;
      tick = gif.vblnk_in && !m_vprev;
      m_vprev = gif.vblnk_in;
      case (m_state)
        M_IDLE: if (gif.start) begin m_state = M_SERVE; m_serve_frames = 0; end
        M_SERVE: if (tick) begin
          m_serve_frames++;
          if (m_serve_frames == SERVE) m_state = M_PLAY;
        end
        M_PLAY: if (tick) model_play_frame();
        M_POINT: if (tick) begin
          if (m_sl == WIN || m_sr == WIN) m_state = M_OVER;
          else begin m_x = X_C; m_y = Y_C; m_serve_frames = 0; m_state = M_SERVE; end
        end
        M_OVER: if (gif.start) begin
          m_sl = 0; m_sr = 0; m_x = X_C; m_y = Y_C; m_right = 1; m_down = 1;
          m_serve_frames = 0; m_state = M_SERVE;
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle scoreboard against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_tests++;
      if (gif.ball_x !== 11'(m_x) || gif.ball_y !== 11'(m_y) || gif.score_l !== 4'(m_sl) ||
          gif.score_r !== 4'(m_sr) || gif.state !== 3'(m_state) ||
          gif.game_over !== (m_state == M_OVER)) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got x=%0d y=%0d sl=%0d sr=%0d st=%0d go=%0d need x=%0d y=%0d sl=%0d sr=%0d st=%0d go=%0d",
                 $time, gif.ball_x, gif.ball_y, gif.score_l, gif.score_r, gif.state, gif.game_over,
                 m_x, m_y, m_sl, m_sr, m_state, (m_state == M_OVER));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_bound(input string name, input int used, input int budget);
    n_tests++;
    if (used >= budget) begin
      n_fail++;
      $display("FAIL %s: waited %0d frames, limit %0d", name, used, budget);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic set_paddles();
    int trk, away;
    trk = (m_y >= 40) ? m_y - 40 : 0;
    away = (m_y >= 120) ? 0 : 400;
    gif.paddle_l_y = 11'(l_away ? away : trk);
    gif.paddle_r_y = 11'(r_away ? away : trk);
  endtask

  task automatic frame();
    set_paddles();
    gif.vblnk_in = 1'b1;
    step();
    step();
    gif.vblnk_in = 1'b0;
    step();
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, int'(gif.ball_x), 392);
    chk({tag, "_y"}, int'(gif.ball_y), 292);
    chk({tag, "_sl"}, int'(gif.score_l), 0);
    chk({tag, "_sr"}, int'(gif.score_r), 0);
    chk({tag, "_state"}, int'(gif.state), 0);
    chk({tag, "_go"}, int'(gif.game_over), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b0;
    gif.vblnk_in = 1'b0;
    gif.start = 1'b0;
    gif.paddle_l_y = '0;
    gif.paddle_r_y = '0;
    step();
    cmp_en = 1;
    repeat (4) step();
    chk_reset_vals("reset");
    rst = 1'b1;
    repeat (3) frame();
    chk_reset_vals("idle_hold");

    // Serve and launch.
    gif.start = 1'b1;
    step();
    gif.start = 1'b0;
    chk("serve_enter", int'(gif.state), 1);
    repeat (59) frame();
    chk("serve_59", int'(gif.state), 1);
    frame();
    chk("serve_60_play", int'(gif.state), 2);
    chk("launch_no_move", int'(gif.ball_x), 392);
    set_paddles();
    chk("pre_tick_x", int'(gif.ball_x), 392);
    gif.vblnk_in = 1'b1;
    step();
    chk("first_move_x", int'(gif.ball_x), 396);
    chk("first_move_y", int'(gif.ball_y), 296);
    step();
    gif.vblnk_in = 1'b0;
    step();
    step();

    // Bottom then top wall bounces.
    g = 0;
    while (!(m_y == 580 && m_down) && g < 400) begin frame(); g++; end
    chk_bound("wait_bottom", g, 400);
    frame();
    chk("bottom_bounce", int'(gif.ball_y), 584);
    frame();
    chk("bottom_after", int'(gif.ball_y), 580);
    g = 0;
    while (!(m_y == 4 && !m_down) && g < 400) begin frame(); g++; end
    chk_bound("wait_top", g, 400);
    frame();
    chk("top_bounce", int'(gif.ball_y), 0);
    frame();
    chk("top_after", int'(gif.ball_y), 4);

    // Left paddle hit with tracking paddle.
    g = 0;
    while (!(m_x == 52 && !m_right) && g < 400) begin frame(); g++; end
    chk_bound("wait_left_hit", g, 400);
    frame();
    chk("left_hit_x", int'(gif.ball_x), 48);
    frame();
    chk("left_hit_rebound", int'(gif.ball_x), 52);

    // Same approach with the left paddle out of the way.
    l_away = 1;
    g = 0;
    while (!(m_x == 52 && !m_right) && g < 800) begin frame(); g++; end
    chk_bound("wait_left_nohit", g, 800);
    frame();
    chk("nohit_x1", int'(gif.ball_x), 48);
    frame();
    chk("nohit_x2", int'(gif.ball_x), 44);
    g = 0;
    while (m_state != M_POINT && g < 100) begin frame(); g++; end
    chk_bound("wait_left_miss", g, 100);
    chk("miss_x", int'(gif.ball_x), 0);
    chk("miss_sr", int'(gif.score_r), 1);
    chk("miss_state", int'(gif.state), 3);
    frame();
    chk("point_to_serve", int'(gif.state), 1);
    chk("recentre_x", int'(gif.ball_x), 392);
    chk("recentre_y", int'(gif.ball_y), 292);
    repeat (60) frame();
    chk("reserve_play", int'(gif.state), 2);
    frame();
    chk("serve_left_x", int'(gif.ball_x), 388);

    // Left player wins by right misses.
    l_away = 0;
    r_away = 1;
    g = 0;
    while (!(m_state == M_POINT && m_sl == WIN) && g < 4000) begin frame(); g++; end
    chk_bound("wait_win", g, 4000);
    chk("win_point_state", int'(gif.state), 3);
    chk("win_sl", int'(gif.score_l), 9);
    chk("win_x", int'(gif.ball_x), 784);
    frame();
    chk("over_state", int'(gif.state), 4);
    chk("over_flag", int'(gif.game_over), 1);
    repeat (10) frame();
    chk("over_hold_x", int'(gif.ball_x), 784);
    chk("over_hold_sl", int'(gif.score_l), 9);
    chk("over_hold_sr", int'(gif.score_r), 1);
    chk("over_hold_state", int'(gif.state), 4);
    gif.start = 1'b1;
    step();
    gif.start = 1'b0;
    chk("restart_sl", int'(gif.score_l), 0);
    chk("restart_sr", int'(gif.score_r), 0);
    chk("restart_state", int'(gif.state), 1);
    chk("restart_go", int'(gif.game_over), 0);
    chk("restart_x", int'(gif.ball_x), 392);

    // Reset in the middle of play, coincident with a frame tick.
    r_away = 0;
    repeat (63) frame();
    chk("midplay_state", int'(gif.state), 2);
    chk("midplay_x", int'(gif.ball_x), 404);
    rst = 1'b0;
    gif.vblnk_in = 1'b1;
    step();
    chk_reset_vals("midplay_reset");
    rst = 1'b1;
    gif.vblnk_in = 1'b0;
    step();
    step();
    chk_reset_vals("after_reset");

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
